// File: rtl/reg_dump_unit_pkg.sv
// Shared types for the register dump engine.
package reg_dump_pkg;

  // Register index width on the read ports.
  localparam int REG_IDX_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND_LO,
    SEND_HI,
    DONE
  } dump_state_t;

endpackage

// File: rtl/reg_dump_unit_if.sv
// Valid/ready beat stream from the dump engine to a debug host.
interface reg_dump_unit_if
  import reg_dump_pkg::*;
#(
  parameter int XLEN = 32
);
  logic [XLEN-1:0]      DumpData;
  logic [REG_IDX_W-1:0] DumpIdx;
  logic                 DumpLast;
  logic                 DumpValid;
  logic                 DumpReady;

  modport master (output DumpData, DumpIdx, DumpLast, DumpValid, input DumpReady);
  modport slave  (input DumpData, DumpIdx, DumpLast, DumpValid, output DumpReady);
endinterface

// File: rtl/reg_dump_unit.sv
// Debug read-out engine: walks the register bank two registers per fetch
// through the borrowed read ports, then streams one word per beat.
module reg_dump_unit
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = 32,  // even, 2..32
  parameter int XLEN     = 32
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic                 Abort,
  output logic [REG_IDX_W-1:0] DumpRs1,
  output logic [REG_IDX_W-1:0] DumpRs2,
  input  logic [XLEN-1:0]      RuRs1,
  input  logic [XLEN-1:0]      RuRs2,
  reg_dump_unit_if.master      dump,
  output logic                 Busy,
  output logic                 Done
);

  localparam int PAIR_W = REG_IDX_W - 1;

  dump_state_t     state;
  logic [PAIR_W-1:0] pair;
  logic [PAIR_W-1:0] pair_inc;
  logic              last_pair;
  logic [XLEN-1:0]   hold_lo;
  logic [XLEN-1:0]   hold_hi;

  assign pair_inc  = pair + PAIR_W'(1);
  assign last_pair = (pair == PAIR_W'(NUM_REGS / 2 - 1));

  // Sequencer: read indices are loaded on entry to FETCH so the bank's
  // combinational read is already settled during the FETCH cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      pair    <= '0;
      hold_lo <= '0;
      hold_hi <= '0;
      DumpRs1 <= '0;
      DumpRs2 <= '0;
    end else if (Abort && state != IDLE) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (Start) begin
          state   <= FETCH;
          pair    <= '0;
          DumpRs1 <= REG_IDX_W'(0);
          DumpRs2 <= REG_IDX_W'(1);
        end
        FETCH: begin
          hold_lo <= RuRs1;
          hold_hi <= RuRs2;
          state   <= SEND_LO;
        end
        SEND_LO: if (dump.DumpReady) state <= SEND_HI;
        SEND_HI: if (dump.DumpReady) begin
          if (last_pair) begin
            state <= DONE;
          end else begin
            pair    <= pair_inc;
            DumpRs1 <= {pair_inc, 1'b0};
            DumpRs2 <= {pair_inc, 1'b1};
            state   <= FETCH;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Beat outputs decode from state and holding registers only, so they stay
  // stable under backpressure and have no path from DumpReady.
  assign dump.DumpValid = (state == SEND_LO) || (state == SEND_HI);
  assign dump.DumpData  = (state == SEND_HI) ? hold_hi : hold_lo;
  assign dump.DumpIdx   = {pair, state == SEND_HI};
  assign dump.DumpLast  = (state == SEND_HI) && last_pair;
  assign Busy           = (state != IDLE);
  assign Done           = (state == DONE);

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit with a small register bank as read target.
module tb_reg_dump_unit;

  logic        Clk = 1'b0;
  logic        Rst, Start, Abort, Start4;
  logic        RuWr;
  logic [4:0]  RuWrIdx;
  logic [31:0] RuWrData;
  logic [4:0]  DumpRs1, DumpRs2, Rs1_4, Rs2_4;
  logic [31:0] RuRs1, RuRs2, Rd1_4, Rd2_4;
  logic        Busy, Done, Busy4, Done4;
  logic [31:0] bank [32];
  logic [31:0] mdl  [32];
  int          nchk = 0;
  int          nfail = 0;

  reg_dump_unit_if #(.XLEN(32)) dv ();
  reg_dump_unit_if #(.XLEN(32)) dv4 ();

  always #5 Clk = ~Clk;

  // Register bank: synchronous write, combinational read, x0 hardwired to 0.
  always @(posedge Clk) if (RuWr && RuWrIdx != 5'd0) bank[RuWrIdx] <= RuWrData;
  assign RuRs1 = (DumpRs1 == 5'd0) ? 32'd0 : bank[DumpRs1];
  assign RuRs2 = (DumpRs2 == 5'd0) ? 32'd0 : bank[DumpRs2];
  assign Rd1_4 = (Rs1_4 == 5'd0) ? 32'd0 : bank[Rs1_4];
  assign Rd2_4 = (Rs2_4 == 5'd0) ? 32'd0 : bank[Rs2_4];

  reg_dump_unit #(.NUM_REGS(32), .XLEN(32)) u_dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Abort(Abort),
    .DumpRs1(DumpRs1), .DumpRs2(DumpRs2), .RuRs1(RuRs1), .RuRs2(RuRs2),
    .dump(dv), .Busy(Busy), .Done(Done));

  reg_dump_unit #(.NUM_REGS(4), .XLEN(32)) u_dut4 (
    .Clk(Clk), .Rst(Rst), .Start(Start4), .Abort(1'b0),
    .DumpRs1(Rs1_4), .DumpRs2(Rs2_4), .RuRs1(Rd1_4), .RuRs2(Rd2_4),
    .dump(dv4), .Busy(Busy4), .Done(Done4));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Pulse Start in cycle 0 and collect beats until Done; optionally write x5
  // during cycle wr_cyc and check the ready-tied-high cycle timing.
  task automatic dump_run(input bit rnd, input int wr_cyc, input bit timing);
    int n, done_c, last_c;
    logic pv, pr, pl;
    logic [31:0] pd;
    logic [4:0] pi;
    n = 0; done_c = -1; last_c = -1; pv = 0; pr = 0; pl = 0; pd = '0; pi = '0;
    @(posedge Clk); #1;
    Start = 1'b1; dv.DumpReady = 1'b1; RuWr = 1'b0;
    for (int c = 1; c < 3000 && done_c < 0; c++) begin
      @(posedge Clk); #1;
      Start = 1'b0;
      dv.DumpReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      RuWr = (c == wr_cyc); RuWrIdx = 5'd5; RuWrData = 32'hDEAD_BEEF;
      @(negedge Clk);
      if (pv && !pr) begin
        chk("hold_valid", 32'(dv.DumpValid), 32'd1);
        chk("hold_data", dv.DumpData, pd);
        chk("hold_idx", 32'(dv.DumpIdx), 32'(pi));
        chk("hold_last", 32'(dv.DumpLast), 32'(pl));
      end
      if (dv.DumpValid && dv.DumpReady) begin
        chk("beat_idx", 32'(dv.DumpIdx), 32'(n));
        chk("beat_data", dv.DumpData, mdl[n[4:0]]);
        chk("beat_last", 32'(dv.DumpLast), 32'(n == 31));
        if (n == 31) last_c = c;
        n++;
      end
      chk("busy", 32'(Busy), 32'd1);
      if (Done) done_c = c;
      pv = dv.DumpValid; pr = dv.DumpReady; pd = dv.DumpData; pi = dv.DumpIdx; pl = dv.DumpLast;
    end
    RuWr = 1'b0;
    chk("beat_count", 32'(n), 32'd32);
    chk("done_seen", 32'(done_c >= 0), 32'd1);
    if (timing) begin
      chk("last_cycle", 32'(last_c), 32'd48);
      chk("done_cycle", 32'(done_c), 32'd49);
    end
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("idle_busy", 32'(Busy), 32'd0);
    chk("idle_done", 32'(Done), 32'd0);
  endtask

  initial begin
    int n, done_c;
    Rst = 1'b1; Start = 1'b0; Abort = 1'b0; Start4 = 1'b0;
    RuWr = 1'b0; RuWrIdx = '0; RuWrData = '0;
    dv.DumpReady = 1'b0; dv4.DumpReady = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_data", dv.DumpData, 32'd0);
    chk("rst_idx", 32'(dv.DumpIdx), 32'd0);
    chk("rst_rs1", 32'(DumpRs1), 32'd0);
    chk("rst_rs2", 32'(DumpRs2), 32'd0);
    chk("rst_valid", 32'(dv.DumpValid), 32'd0);
    chk("rst_last", 32'(dv.DumpLast), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst4_valid", 32'(dv4.DumpValid), 32'd0);
    Rst = 1'b0;

    // Preload xN = 0xA5A5_0000 + N
    mdl[0] = 32'd0;
    for (int i = 1; i < 32; i++) begin
      @(posedge Clk); #1;
      RuWr = 1'b1; RuWrIdx = 5'(i); RuWrData = 32'hA5A5_0000 + 32'(i);
      mdl[i] = 32'hA5A5_0000 + 32'(i);
    end
    @(posedge Clk); #1;
    RuWr = 1'b0;

    // Full dump, ready tied high, with cycle timing
    dump_run(1'b0, -1, 1'b1);
    // Random backpressure
    dump_run(1'b1, -1, 1'b0);
    // Write x5 during FETCH of pair 2 (cycle 7): old value dumped
    dump_run(1'b0, 7, 1'b0);
    mdl[5] = 32'hDEAD_BEEF;
    dump_run(1'b0, -1, 1'b0);

    // Abort in SEND_HI of pair 7 (cycle 24) with ready low
    @(posedge Clk); #1;
    Start = 1'b1; dv.DumpReady = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(posedge Clk); #1;
      Start = 1'b0;
      dv.DumpReady = (c < 24);
      Abort = (c == 24);
      @(negedge Clk);
      if (c == 24) begin
        chk("abort_pre_valid", 32'(dv.DumpValid), 32'd1);
        chk("abort_pre_idx", 32'(dv.DumpIdx), 32'd15);
      end
    end
    @(posedge Clk); #1;
    Abort = 1'b0;
    @(negedge Clk);
    chk("abort_valid", 32'(dv.DumpValid), 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    done_c = 0;
    repeat (5) begin
      @(negedge Clk);
      if (Done || dv.DumpValid) done_c++;
    end
    chk("abort_no_done", 32'(done_c), 32'd0);
    dump_run(1'b0, -1, 1'b0);

    // Reset in SEND_LO of pair 3 (cycle 11); Start in cycle 5 is ignored
    @(posedge Clk); #1;
    Start = 1'b1; dv.DumpReady = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(posedge Clk); #1;
      Start = (c == 5);
      Rst = (c == 11);
      @(negedge Clk);
      if (c == 6) chk("busy_start_idx", 32'(dv.DumpIdx), 32'd3);
      if (c == 6) chk("busy_start_valid", 32'(dv.DumpValid), 32'd1);
      if (c == 11) chk("pre_rst_idx", 32'(dv.DumpIdx), 32'd6);
    end
    @(posedge Clk); #1;
    Rst = 1'b0; Start = 1'b0;
    @(negedge Clk);
    chk("mid_rst_data", dv.DumpData, 32'd0);
    chk("mid_rst_idx", 32'(dv.DumpIdx), 32'd0);
    chk("mid_rst_rs1", 32'(DumpRs1), 32'd0);
    chk("mid_rst_rs2", 32'(DumpRs2), 32'd0);
    chk("mid_rst_valid", 32'(dv.DumpValid), 32'd0);
    chk("mid_rst_last", 32'(dv.DumpLast), 32'd0);
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    chk("mid_rst_done", 32'(Done), 32'd0);
    repeat (3) @(negedge Clk);
    chk("post_rst_busy", 32'(Busy), 32'd0);

    // NUM_REGS = 4 instance
    n = 0; done_c = -1;
    @(posedge Clk); #1;
    Start4 = 1'b1;
    for (int c = 1; c < 20 && done_c < 0; c++) begin
      @(posedge Clk); #1;
      Start4 = 1'b0;
      @(negedge Clk);
      if (dv4.DumpValid && dv4.DumpReady) begin
        chk("n4_idx", 32'(dv4.DumpIdx), 32'(n));
        chk("n4_data", dv4.DumpData, mdl[n[4:0]]);
        chk("n4_last", 32'(dv4.DumpLast), 32'(n == 3));
        n++;
      end
      if (Done4) done_c = c;
    end
    chk("n4_count", 32'(n), 32'd4);
    chk("n4_done_cycle", 32'(done_c), 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
